// File: rtl/mem_responder.sv
// mem_responder: word-addressed storage with fixed-latency reads.
// Define MEM_RESPONDER_RANGE_ERR_EN to enable the out-of-range err pulse.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h3000,
  parameter int unsigned LATENCY    = 2,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        wvalid,
  input  logic        rreq,
  output logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic [31:0]           r_addr;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_idle;
  logic                  w_wr_ok;
  logic                  w_win;
  logic                  w_rin;
  logic                  w_fwd;
  logic [32:0]           w_woff;
  logic [32:0]           w_roff;
  logic [31:0]           w_raddr;
  logic [31:0]           w_rword;
  logic [DEPTH_LOG2-1:0] w_widx;
  logic [DEPTH_LOG2-1:0] w_ridx;

  assign w_idle  = (r_state == IDLE);

  // Range check as one subtraction: any set bit above the index
  // field means below base (borrow) or past the top.
  assign w_woff  = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
  assign w_win   = (w_woff[32:DEPTH_LOG2] == '0);
  assign w_widx  = w_woff[DEPTH_LOG2-1:0];
  assign w_wr_ok = rst_n && w_idle && wvalid && w_win;

  assign w_raddr = w_idle ? mem_addr : r_addr;
  assign w_roff  = {1'b0, w_raddr} - {1'b0, BASE_ADDR};
  assign w_rin   = (w_roff[32:DEPTH_LOG2] == '0);
  assign w_ridx  = w_roff[DEPTH_LOG2-1:0];

  // Single-cycle reads see a same-cycle write only via this bypass.
  assign w_fwd   = w_idle && wvalid;
  assign w_rword = !w_rin ? '0 :
                   w_fwd  ? mem_wdata :
                            r_mem[w_ridx];

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_widx] <= mem_wdata;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (rreq) begin
          if (LATENCY == 1) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_next     = RESP;
          w_cnt_next = '0;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_idle && rreq) begin
        r_addr <= mem_addr;
      end
      if (w_next == RESP) begin
        r_rdata <= w_rword;
      end
    end
  end

  assign rvalid    = (r_state == RESP);
  assign busy      = !w_idle;
  assign mem_rdata = r_rdata;

`ifdef MEM_RESPONDER_RANGE_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_idle && wvalid && !w_win) ||
               (w_next == RESP && !w_rin);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table, corner sequences and a
// random run against a transaction-level model of mem_responder.
module tb_mem_responder;

`ifdef MEM_RESPONDER_RANGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int unsigned LAT = 2;

  localparam logic [1:0] N  = 2'b00;
  localparam logic [1:0] R  = 2'b01;
  localparam logic [1:0] W  = 2'b10;
  localparam logic [1:0] WR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] a0, wd0, rd0;
  logic        wv0, rq0, rv0, bz0, er0;
  logic [31:0] a1, wd1, rd1;
  logic        wv1, rq1, rv1, bz1, er1;

  always #5 clk = ~clk;

  mem_responder u0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (a0),
    .mem_wdata (wd0),
    .wvalid    (wv0),
    .rreq      (rq0),
    .mem_rdata (rd0),
    .rvalid    (rv0),
    .busy      (bz0),
    .err       (er0)
  );

  mem_responder #(.LATENCY(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (a1),
    .mem_wdata (wd1),
    .wvalid    (wv1),
    .rreq      (rq1),
    .mem_rdata (rd1),
    .rvalid    (rv1),
    .busy      (bz1),
    .err       (er1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [2:0]  fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [1:0] op,
                             input logic [31:0] a, wd, rd,
                             input logic [2:0] fl);
    vec_t t;
    t.op = op;
    t.a  = a;
    t.wd = wd;
    t.rd = rd;
    t.fl = fl;
    return t;
  endfunction

  // Reference model: storage array plus one pending read
  // with the cycle number on which its response is due.
  logic [31:0] m_mem [1024];
  bit          m_pend;
  int unsigned m_due;
  logic [31:0] m_pdata;
  bit          m_perr;
  logic [31:0] m_rdata;
  bit          m_werr;
  int unsigned cyc;

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h3000) && (a < 32'h3400);
  endfunction

  task automatic step0(input bit wv, input bit rq,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    bit         fire;
    logic [9:0] ix;
    fire = m_pend && (m_due == cyc);
    if (fire) m_rdata = m_pdata;
    chk1("rnd.rvalid", rv0, fire);
    chk32("rnd.rdata", rd0, m_rdata);
    chk1("rnd.busy", bz0, m_pend);
    chk1("rnd.err", er0, ERR_EN && (m_werr || (fire && m_perr)));
    wv0 = wv;
    rq0 = rq;
    a0  = a;
    wd0 = wd;
    ix  = 10'(a - 32'h3000);
    m_werr = 1'b0;
    if (!m_pend) begin
      if (wv) begin
        if (in_rng(a)) m_mem[ix] = wd;
        else m_werr = 1'b1;
      end
      if (rq) begin
        m_pend  = 1'b1;
        m_due   = cyc + LAT;
        m_pdata = in_rng(a) ? m_mem[ix] : 32'h0;
        m_perr  = !in_rng(a);
      end
    end else if (fire) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [31:0] v1 [4];
  logic [31:0] ra;
  logic [31:0] rw;
  bit          rwv;
  bit          rrq;

  initial begin
    rst_n = 1'b0;
    {wv0, rq0, wv1, rq1} = '0;
    {a0, wd0, a1, wd1} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst.rvalid", rv0, 1'b0);
    chk1("rst.busy", bz0, 1'b0);
    chk1("rst.err", er0, 1'b0);
    chk32("rst.rdata", rd0, 32'h0);
    chk1("rst1.rvalid", rv1, 1'b0);
    chk1("rst1.busy", bz1, 1'b0);
    chk32("rst1.rdata", rd1, 32'h0);
    rst_n = 1'b1;

    // fl = {rvalid, busy, err} in the cycle after the inputs
    tbl.push_back(v(W,  32'h3000, 32'hDEADBEEF, 32'h0, 3'b000));
    tbl.push_back(v(R,  32'h3000, 32'h0, 32'h0, 3'b010));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'hDEADBEEF, 3'b110));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'hDEADBEEF, 3'b000));
    tbl.push_back(v(WR, 32'h3005, 32'h12345678, 32'hDEADBEEF, 3'b010));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h12345678, 3'b110));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h12345678, 3'b000));
    tbl.push_back(v(W,  32'h3001, 32'hCAFEF00D, 32'h12345678, 3'b000));
    tbl.push_back(v(R,  32'h3001, 32'h0, 32'h12345678, 3'b010));
    tbl.push_back(v(WR, 32'h3001, 32'h1, 32'hCAFEF00D, 3'b110));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'hCAFEF00D, 3'b000));
    tbl.push_back(v(R,  32'h3001, 32'h0, 32'hCAFEF00D, 3'b010));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'hCAFEF00D, 3'b110));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'hCAFEF00D, 3'b000));
    tbl.push_back(v(R,  32'h2FFF, 32'h0, 32'hCAFEF00D, 3'b010));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h0, 3'b111));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h0, 3'b000));
    tbl.push_back(v(R,  32'h3400, 32'h0, 32'h0, 3'b010));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h0, 3'b111));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h0, 3'b000));
    tbl.push_back(v(W,  32'h3400, 32'hFFFFFFFF, 32'h0, 3'b001));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h0, 3'b000));
    tbl.push_back(v(R,  32'h3000, 32'h0, 32'h0, 3'b010));
    tbl.push_back(v(W,  32'h3005, 32'h55555555, 32'hDEADBEEF, 3'b110));
    tbl.push_back(v(R,  32'h3001, 32'h0, 32'hDEADBEEF, 3'b000));
    tbl.push_back(v(R,  32'h3005, 32'h0, 32'hDEADBEEF, 3'b010));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h12345678, 3'b110));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'h12345678, 3'b000));
    tbl.push_back(v(W,  32'h33FF, 32'hA5A5A5A5, 32'h12345678, 3'b000));
    tbl.push_back(v(R,  32'h33FF, 32'h0, 32'h12345678, 3'b010));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'hA5A5A5A5, 3'b110));
    tbl.push_back(v(N,  32'h0, 32'h0, 32'hA5A5A5A5, 3'b000));

    for (int i = 0; i < tbl.size(); i++) begin
      {wv0, rq0} = tbl[i].op;
      a0  = tbl[i].a;
      wd0 = tbl[i].wd;
      @(posedge clk);
      #1;
      chk1($sformatf("vec%0d.rvalid", i), rv0, tbl[i].fl[2]);
      chk1($sformatf("vec%0d.busy", i), bz0, tbl[i].fl[1]);
      chk1($sformatf("vec%0d.err", i), er0, tbl[i].fl[0] && ERR_EN);
      chk32($sformatf("vec%0d.rdata", i), rd0, tbl[i].rd);
    end
    {wv0, rq0} = '0;

    // Reset one cycle into an outstanding read.
    rq0 = 1'b1;
    a0  = 32'h3000;
    @(posedge clk);
    #1;
    chk1("abort.busy_before", bz0, 1'b1);
    rq0   = 1'b0;
    a0    = 32'h0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk1("abort.rvalid", rv0, 1'b0);
    chk1("abort.busy", bz0, 1'b0);
    chk1("abort.err", er0, 1'b0);
    chk32("abort.rdata", rd0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("abort.quiet%0d", i), rv0, 1'b0);
    end
    rq0 = 1'b1;
    a0  = 32'h3000;
    @(posedge clk);
    #1;
    rq0 = 1'b0;
    @(posedge clk);
    #1;
    chk1("abort.reread_valid", rv0, 1'b1);
    chk32("abort.reread_data", rd0, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Single-cycle latency instance: rreq held high.
    v1[0] = 32'h11111111;
    v1[1] = 32'h22222222;
    v1[2] = 32'h33333333;
    v1[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      wv1 = 1'b1;
      a1  = 32'h3000 + 32'(i);
      wd1 = v1[i];
      @(posedge clk);
      #1;
      chk1($sformatf("l1.wr%0d_busy", i), bz1, 1'b0);
    end
    wv1 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      rq1 = 1'b1;
      a1  = 32'h3000 + 32'(j % 4);
      @(posedge clk);
      #1;
      if (j % 2 == 0) begin
        chk1($sformatf("l1.b2b%0d_rvalid", j), rv1, 1'b1);
        chk1($sformatf("l1.b2b%0d_busy", j), bz1, 1'b1);
        chk32($sformatf("l1.b2b%0d_rdata", j), rd1, v1[j % 4]);
      end else begin
        chk1($sformatf("l1.b2b%0d_rvalid", j), rv1, 1'b0);
        chk1($sformatf("l1.b2b%0d_busy", j), bz1, 1'b0);
        chk32($sformatf("l1.b2b%0d_rdata", j), rd1, v1[(j - 1) % 4]);
      end
    end
    wv1 = 1'b1;
    rq1 = 1'b1;
    a1  = 32'h3007;
    wd1 = 32'h77777777;
    @(posedge clk);
    #1;
    chk1("l1.fwd_rvalid", rv1, 1'b1);
    chk32("l1.fwd_rdata", rd1, 32'h77777777);
    chk1("l1.fwd_err", er1, 1'b0);
    wv1 = 1'b0;
    a1  = 32'h3400;
    @(posedge clk);
    #1;
    chk1("l1.oor_idle", rv1, 1'b0);
    @(posedge clk);
    #1;
    chk1("l1.oor_rvalid", rv1, 1'b1);
    chk32("l1.oor_rdata", rd1, 32'h0);
    chk1("l1.oor_err", er1, ERR_EN);
    rq1 = 1'b0;

    // Random traffic against the model.
    {wv0, rq0} = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_pend  = 1'b0;
    m_rdata = 32'h0;
    m_werr  = 1'b0;
    cyc     = 0;
    for (int i = 0; i < 16; i++) begin
      step0(1'b1, 1'b0, 32'h3000 + 32'(i), $urandom);
    end
    step0(1'b1, 1'b0, 32'h33FF, $urandom);
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: ra = 32'h3000 + $urandom_range(0, 15);
        3:       ra = 32'h33FF;
        4: begin
          case ($urandom_range(0, 3))
            0:       ra = 32'h2FFF;
            1:       ra = 32'h3400;
            2:       ra = 32'h0;
            default: ra = 32'hFFFFFFFF;
          endcase
        end
        default: ra = $urandom | 32'h80000000;
      endcase
      rw  = $urandom;
      rwv = ($urandom_range(0, 9) < 4);
      rrq = ($urandom_range(0, 9) < 4);
      step0(rwv, rrq, ra, rw);
    end
    for (int i = 0; i < 4; i++) begin
      step0(1'b0, 1'b0, 32'h0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
